// File: rtl/t_toggle_pulse_gen_pkg.sv
// Shared definitions for the pushbutton T-pulse feeder: FSM encodings and
// debounce lengths for simulation and board builds.
package t_toggle_pulse_gen_pkg;

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_PRESSED      = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  localparam int DEBOUNCE_SIM   = 4;
  localparam int DEBOUNCE_BOARD = 500000;

endpackage

// File: rtl/btn_synchronizer.sv
// Multi-flop synchroniser bringing the asynchronous pushbutton into the clk domain.
module btn_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], d};
  end

  assign q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/t_toggle_pulse_gen.sv
// Pushbutton to T-drive converter: synchronise, debounce, and emit one
// registered 1-cycle T pulse per accepted press, plus level and press count.
module t_toggle_pulse_gen
  import t_toggle_pulse_gen_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  input  logic             en,
  output logic             T,
  output logic             btn_db,
  output logic [CNT_W-1:0] press_cnt
);

  localparam int              CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic             w_btn_sync;
  logic [1:0]       r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             w_accept;
  logic             r_t;
  logic [CNT_W-1:0] r_press_cnt;

  btn_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (w_btn_sync)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_btn_sync) begin
          w_state_nxt = S_PRESS_WAIT;
          w_cnt_nxt   = CW'(1);
        end
      end
      S_PRESS_WAIT: begin
        if (!w_btn_sync) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_PRESSED;
          w_cnt_nxt   = '0;
          w_accept    = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      S_PRESSED: begin
        if (!w_btn_sync) begin
          w_state_nxt = S_RELEASE_WAIT;
          w_cnt_nxt   = CW'(1);
        end
      end
      default: begin
        // A bounce back high during release re-arms PRESSED without a new pulse.
        if (w_btn_sync) begin
          w_state_nxt = S_PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_t         <= 1'b0;
      r_press_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_t         <= w_accept & en;
      if (w_accept) r_press_cnt <= r_press_cnt + CNT_W'(1);
    end
  end

  // PRESSED and RELEASE_WAIT share the top encoding bit, so it is the debounced level.
  assign btn_db    = r_state[1];
  assign T         = r_t;
  assign press_cnt = r_press_cnt;

endmodule

// File: tb/tb_t_toggle_pulse_gen.sv
// Self-checking bench: press table plus hand sequences, T pulses checked
// against a scoreboard of expected (cycle, count) entries.
module tb_t_toggle_pulse_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b1;
  logic       en = 1'b1;
  logic       T, btn_db, T_w, db_w;
  logic [7:0] press_cnt;
  logic [1:0] press_cnt_w;

  t_toggle_pulse_gen u_dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .en(en),
    .T(T), .btn_db(btn_db), .press_cnt(press_cnt)
  );

  t_toggle_pulse_gen #(.CNT_W(2)) u_dut_w (
    .clk(clk), .rst(rst), .btn_in(btn_in), .en(en),
    .T(T_w), .btn_db(db_w), .press_cnt(press_cnt_w)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int cnt; } exp_t;
  typedef struct { int hold; bit en; bit acc; } vec_t;

  exp_t sb[$];
  vec_t vt[8];
  int   hs[3];
  int   n_cmp = 0, n_bad = 0, exp_cnt = 0;

  task automatic chk(string name, logic [31:0] act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (T === 1'b1) begin
      if (sb.size() == 0) chk("T_unexpected", cyc, -1);
      else begin
        e = sb.pop_front();
        chk("T_cycle", cyc, e.cyc);
        chk("cnt_at_T", press_cnt, e.cnt % 256);
        chk("db_at_T", btn_db, 1);
        chk("T_w", T_w, 1);
        chk("cnt_w_at_T", press_cnt_w, e.cnt % 4);
      end
    end
  end

  task automatic press(int hold, bit en_v, bit acc);
    int c0;
    en = en_v;
    btn_in = 1'b1;
    c0 = cyc;
    if (acc) begin
      exp_cnt++;
      if (en_v) sb.push_back('{c0 + 6, exp_cnt});
    end
    repeat (hold) @(negedge clk);
    btn_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("db_before_rel", btn_db, int'(acc));
    @(negedge clk);
    chk("db_after_rel", btn_db, 0);
    repeat (3) @(negedge clk);
    chk("press_cnt", press_cnt, exp_cnt % 256);
    chk("press_cnt_w", press_cnt_w, exp_cnt % 4);
  endtask

  initial begin
    int c0;
    vt[0] = '{20, 1'b1, 1'b1};
    vt[1] = '{1,  1'b1, 1'b0};
    vt[2] = '{3,  1'b1, 1'b0};
    vt[3] = '{4,  1'b1, 1'b1};
    vt[4] = '{6,  1'b0, 1'b1};
    vt[5] = '{5,  1'b1, 1'b1};
    vt[6] = '{2,  1'b1, 1'b0};
    vt[7] = '{8,  1'b1, 1'b1};
    hs = '{1, 2, 3};

    // Reset held with the button pressed
    repeat (3) begin
      @(negedge clk);
      chk("rst_T", T, 0);
      chk("rst_db", btn_db, 0);
      chk("rst_cnt", press_cnt, 0);
    end
    rst = 1'b0;
    c0 = cyc;
    exp_cnt = 1;
    sb.push_back('{c0 + 6, exp_cnt});
    repeat (12) @(negedge clk);
    btn_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("cnt_after_rst_press", press_cnt, 1);

    for (int i = 0; i < 8; i++) press(vt[i].hold, vt[i].en, vt[i].acc);

    // Bounce: 1,2,3-cycle highs with 1-cycle lows, then stable high
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      btn_in = 1'b1;
      repeat (hs[i]) @(negedge clk);
      btn_in = 1'b0;
      @(negedge clk);
    end
    btn_in = 1'b1;
    c0 = cyc;
    exp_cnt++;
    sb.push_back('{c0 + 6, exp_cnt});
    repeat (12) @(negedge clk);

    // Release bounce while PRESSED: level stays high, no pulse
    btn_in = 1'b0;
    repeat (2) @(negedge clk);
    btn_in = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("db_rel_bounce", btn_db, 1);
    end
    btn_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("db_rel_done", btn_db, 0);
    chk("cnt_rel_bounce", press_cnt, exp_cnt % 256);

    // Enable raised mid-hold: counted, never pulsed
    en = 1'b0;
    btn_in = 1'b1;
    exp_cnt++;
    repeat (10) @(negedge clk);
    en = 1'b1;
    repeat (10) @(negedge clk);
    btn_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("cnt_en_mid", press_cnt, exp_cnt % 256);
    press(10, 1'b1, 1'b1);

    // Reset asserted mid PRESS_WAIT, button still held at release
    btn_in = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_T", T, 0);
    chk("async_rst_db", btn_db, 0);
    chk("async_rst_cnt", press_cnt, 0);
    chk("async_rst_cnt_w", press_cnt_w, 0);
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    c0 = cyc;
    exp_cnt = 1;
    sb.push_back('{c0 + 6, exp_cnt});
    repeat (12) @(negedge clk);
    btn_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("cnt_post_rst", press_cnt, 1);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
